// File: rtl/shifter_pkg.sv
// Shared types for the shifter datapath and its arbiter.
package shifter_pkg;

    localparam int unsigned SHIFT_N = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'd0,
        SHIFT_SRL  = 2'd1,
        SHIFT_SRA  = 2'd2,
        SHIFT_PASS = 2'd3
    } shift_op_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [NREQ-1:0] rot;

    // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                if (32'(ptr) + k >= NREQ) begin
                    idx = IW'(32'(ptr) + k - NREQ);
                end else begin
                    idx = IW'(32'(ptr) + k);
                end
            end
        end
        if (valid) begin
            grant = NREQ'(1) << idx;
        end
    end

endmodule

// File: rtl/sll.sv
// Logical left shift.
module sll #(
    parameter int unsigned N  = 32,
    parameter int unsigned SW = 5
) (
    input  logic [N-1:0]  din,
    input  logic [SW-1:0] shamt,
    output logic [N-1:0]  dout
);

    assign dout = din << shamt;

endmodule

// File: rtl/sra.sv
// Arithmetic right shift, sign fill from the MSB.
module sra #(
    parameter int unsigned N  = 32,
    parameter int unsigned SW = 5
) (
    input  logic [N-1:0]  din,
    input  logic [SW-1:0] shamt,
    output logic [N-1:0]  dout
);

    assign dout = N'($signed(din) >>> shamt);

endmodule

// File: rtl/srl.sv
// Logical right shift, zero fill.
module srl #(
    parameter int unsigned N  = 32,
    parameter int unsigned SW = 5
) (
    input  logic [N-1:0]  din,
    input  logic [SW-1:0] shamt,
    output logic [N-1:0]  dout
);

    assign dout = din >> shamt;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin shared shifter with a one-entry tagged result register.
// Optional per-requester accept counters: define SHIFT_ARB_STATS_EN.
module shift_arbiter
    import shifter_pkg::*;
#(
    parameter  int unsigned N    = SHIFT_N,
    parameter  int unsigned NREQ = 2,
    localparam int unsigned SW   = $clog2(N),
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SHIFT_ARB_STATS_EN
    output logic [NREQ*16-1:0] grant_count,
`endif
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*N-1:0]  req_in,
    input  logic [NREQ*SW-1:0] req_shamt,
    input  logic [NREQ*2-1:0]  req_op,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [N-1:0]       resp_out,
    output logic [IW-1:0]      resp_id
);

    arb_state_t      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_onehot;
    logic            gnt_valid;
    logic            can_accept;
    logic            accept;
    logic [N-1:0]    sel_in;
    logic [SW-1:0]   sel_shamt;
    shift_op_t       sel_op;
    logic [N-1:0]    sll_out;
    logic [N-1:0]    srl_out;
    logic [N-1:0]    sra_out;
    logic [N-1:0]    shift_res;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt_onehot),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    // Route the granted requester's payload to the shared datapath.
    always_comb begin
        sel_in    = '0;
        sel_shamt = '0;
        sel_op    = SHIFT_PASS;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_in    = req_in[i*N +: N];
                sel_shamt = req_shamt[i*SW +: SW];
                sel_op    = shift_op_t'(req_op[i*2 +: 2]);
            end
        end
    end

    sll #(.N(N), .SW(SW)) u_sll (.din(sel_in), .shamt(sel_shamt), .dout(sll_out));
    srl #(.N(N), .SW(SW)) u_srl (.din(sel_in), .shamt(sel_shamt), .dout(srl_out));
    sra #(.N(N), .SW(SW)) u_sra (.din(sel_in), .shamt(sel_shamt), .dout(sra_out));

    // 4:1 result mux; PASS ignores the shift amount.
    always_comb begin
        shift_res = sel_in;
        unique case (sel_op)
            SHIFT_SLL:  shift_res = sll_out;
            SHIFT_SRL:  shift_res = srl_out;
            SHIFT_SRA:  shift_res = sra_out;
            SHIFT_PASS: shift_res = sel_in;
            default:    shift_res = sel_in;
        endcase
    end

    // Accept when the result slot is free or is being drained this cycle.
    always_comb begin
        can_accept = (state == ST_EMPTY) || (resp_valid && resp_ready);
        accept     = can_accept && gnt_valid;
        req_ready  = (rst_n && can_accept) ? gnt_onehot : '0;
    end

    // Result register FSM: load on accept, clear valid on drain-only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_out   <= '0;
            resp_id    <= '0;
        end else begin
            if (accept) begin
                state      <= ST_FULL;
                resp_valid <= 1'b1;
                resp_out   <= shift_res;
                resp_id    <= gnt_idx;
                rr_ptr     <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            end else if (state == ST_FULL && resp_ready) begin
                state      <= ST_EMPTY;
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    // Per-requester wrapping accept counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt_onehot[i]) begin
                    grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter (NREQ=2, N=32).
// Build with SHIFT_ARB_STATS_EN to also check the accept counters.
module tb_shift_arbiter;

    localparam int unsigned N    = 32;
    localparam int unsigned NREQ = 2;
    localparam int unsigned SW   = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*N-1:0]  req_in;
    logic [NREQ*SW-1:0] req_shamt;
    logic [NREQ*2-1:0]  req_op;
    logic               resp_valid;
    logic               resp_ready;
    logic [N-1:0]       resp_out;
    logic [0:0]         resp_id;
`ifdef SHIFT_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_count;
`endif

    shift_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SHIFT_ARB_STATS_EN
        .grant_count(grant_count),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in     (req_in),
        .req_shamt  (req_shamt),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state: slot occupancy, next-priority requester, held result.
    bit          m_full;
    int          m_ptr;
    logic [31:0] m_out;
    int          m_id;
    logic [1:0]  m_rdy;
    int          m_cnt [NREQ];

    localparam int OP_SLL = 0, OP_SRL = 1, OP_SRA = 2, OP_PASS = 3;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] in0;
        int          sh0;
        int          op0;
        logic [31:0] in1;
        int          sh1;
        int          op1;
        logic        rready;
        logic [1:0]  exp_rdy;
        logic        exp_rv;
        logic [31:0] exp_out;
        int          exp_id;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Shift result from arithmetic: multiply / divide by powers of two.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s, input int op);
        longint p;
        longint sx;
        p = longint'(1) << s;
        case (op)
            OP_SLL:  return 32'(longint'(x) * p);
            OP_SRL:  return 32'(longint'(x) / p);
            OP_SRA: begin
                sx = longint'($signed(x));
                if (sx >= 0) return 32'(sx / p);
                else         return 32'(-((-sx + p - 1) / p));
            end
            default: return x;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [31:0] d, input int s, input int op);
        req_in[i*N +: N]     = d;
        req_shamt[i*SW +: SW] = SW'(s);
        req_op[i*2 +: 2]     = 2'(op);
    endtask

    task automatic model_reset();
        m_full = 0;
        m_ptr  = 0;
        m_out  = '0;
        m_id   = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    // One clock of stimulus already driven; checks ready, then registered outputs.
    task automatic run_cycle(input bit use_tbl, input vec_t v);
        int  w;
        bit  can;
        #1;
        can   = !m_full || resp_ready;
        w     = -1;
        m_rdy = '0;
        if (can) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (w < 0 && req_valid[j]) w = j;
            end
            if (w >= 0) m_rdy[w] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(use_tbl ? v.exp_rdy : m_rdy));
        @(posedge clk);
        if (w >= 0) begin
            m_out  = ref_shift(req_in[w*N +: N], int'(req_shamt[w*SW +: SW]), int'(req_op[w*2 +: 2]));
            m_id   = w;
            m_full = 1;
            m_ptr  = (w + 1) % NREQ;
            m_cnt[w] = (m_cnt[w] + 1) % 65536;
        end else if (m_full && resp_ready) begin
            m_full = 0;
        end
        #1;
        chk("resp_valid", 32'(resp_valid), use_tbl ? 32'(v.exp_rv)  : 32'(m_full));
        chk("resp_out",   resp_out,        use_tbl ? v.exp_out      : m_out);
        chk("resp_id",    32'(resp_id),    use_tbl ? 32'(v.exp_id)  : 32'(m_id));
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [1:0] va,
                                input logic [31:0] i0, input int s0, input int o0,
                                input logic [31:0] i1, input int s1, input int o1,
                                input logic rr, input logic [1:0] er, input logic erv,
                                input logic [31:0] eo, input int eid);
        vec_t v;
        v.valid = va; v.in0 = i0; v.sh0 = s0; v.op0 = o0;
        v.in1 = i1; v.sh1 = s1; v.op1 = o1; v.rready = rr;
        v.exp_rdy = er; v.exp_rv = erv; v.exp_out = eo; v.exp_id = eid;
        return v;
    endfunction

    vec_t       dummy;
    bit         pend [NREQ];
    logic [1:0] last_rdy;

    initial begin
        dummy = mk(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 2'b00, 1'b0, 0, 0);

        // Directed table, starting right after reset (pointer 0, slot empty).
        tbl.push_back(mk(2'b01, 32'h8000_0000, 4, OP_SRA, 32'h0, 0, OP_PASS, 1'b1, 2'b01, 1'b1, 32'hF800_0000, 0));
        tbl.push_back(mk(2'b11, 32'h0000_0001, 31, OP_SLL, 32'hF000_000F, 31, OP_SRL, 1'b0, 2'b00, 1'b1, 32'hF800_0000, 0));
        tbl.push_back(mk(2'b11, 32'h0000_0001, 31, OP_SLL, 32'hF000_000F, 31, OP_SRL, 1'b0, 2'b00, 1'b1, 32'hF800_0000, 0));
        tbl.push_back(mk(2'b11, 32'h0000_0001, 31, OP_SLL, 32'hF000_000F, 31, OP_SRL, 1'b1, 2'b10, 1'b1, 32'h0000_0001, 1));
        tbl.push_back(mk(2'b11, 32'h0000_0001, 31, OP_SLL, 32'hF000_000F, 31, OP_SRA, 1'b0, 2'b00, 1'b1, 32'h0000_0001, 1));
        tbl.push_back(mk(2'b11, 32'h0000_0001, 31, OP_SLL, 32'hF000_000F, 31, OP_SRA, 1'b1, 2'b01, 1'b1, 32'h8000_0000, 0));
        tbl.push_back(mk(2'b10, 32'h0, 0, OP_PASS, 32'hF000_000F, 31, OP_SRA, 1'b0, 2'b00, 1'b1, 32'h8000_0000, 0));
        tbl.push_back(mk(2'b10, 32'h0, 0, OP_PASS, 32'hF000_000F, 31, OP_SRA, 1'b1, 2'b10, 1'b1, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(2'b00, 32'h0, 0, OP_PASS, 32'h0, 0, OP_PASS, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(2'b10, 32'h0, 0, OP_PASS, 32'hF000_000F, 31, OP_PASS, 1'b0, 2'b10, 1'b1, 32'hF000_000F, 1));
        tbl.push_back(mk(2'b01, 32'hF000_000F, 0, OP_SLL, 32'h0, 0, OP_PASS, 1'b1, 2'b01, 1'b1, 32'hF000_000F, 0));
        tbl.push_back(mk(2'b10, 32'h0, 0, OP_PASS, 32'hF000_000F, 0, OP_SRA, 1'b1, 2'b10, 1'b1, 32'hF000_000F, 1));
        tbl.push_back(mk(2'b01, 32'hF000_000F, 0, OP_SRL, 32'h0, 0, OP_PASS, 1'b1, 2'b01, 1'b1, 32'hF000_000F, 0));
        tbl.push_back(mk(2'b00, 32'h0, 0, OP_PASS, 32'h0, 0, OP_PASS, 1'b1, 2'b00, 1'b0, 32'hF000_000F, 0));

        // Reset: outputs cleared and no ready even with requests pending.
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_in     = '0;
        req_shamt  = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_out",   resp_out,        32'd0);
        chk("rst_resp_id",    32'(resp_id),    32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        foreach (tbl[t]) begin
            req_valid  = tbl[t].valid;
            set_req(0, tbl[t].in0, tbl[t].sh0, tbl[t].op0);
            set_req(1, tbl[t].in1, tbl[t].sh1, tbl[t].op1);
            resp_ready = tbl[t].rready;
            run_cycle(1'b1, tbl[t]);
        end

        // Backpressure: SLL 1 by 31 held for 5 cycles, then drain + accept together.
        req_valid  = 2'b01;
        set_req(0, 32'h0000_0001, 31, OP_SLL);
        resp_ready = 1'b0;
        run_cycle(1'b0, dummy);
        chk("bp_load", resp_out, 32'h8000_0000);
        req_valid = 2'b11;
        set_req(0, 32'h0000_00F0, 4, OP_SRL);
        set_req(1, 32'h1234_5678, 8, OP_SLL);
        repeat (5) begin
            run_cycle(1'b0, dummy);
            chk("bp_hold_out", resp_out, 32'h8000_0000);
        end
        resp_ready = 1'b1;
        run_cycle(1'b0, dummy);
        chk("bp_drain_accept", resp_out, 32'h3456_7800);

        // Contention: both valid, consumer always ready -> alternating grants.
        for (int c = 0; c < 8; c++) begin
            req_valid = 2'b11;
            set_req(0, $urandom, $urandom_range(0, 31), $urandom_range(0, 3));
            set_req(1, $urandom, $urandom_range(0, 31), $urandom_range(0, 3));
            resp_ready = 1'b1;
            run_cycle(1'b0, dummy);
            chk("alt_id", 32'(resp_id), 32'(c % 2));
        end

        // Randomized traffic; requesters hold payload until accepted.
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 55)) begin
                    pend[i] = 1;
                    case ($urandom_range(0, 3))
                        0:       set_req(i, 32'h8000_0000, $urandom_range(0, 31), $urandom_range(0, 3));
                        1:       set_req(i, $urandom, 0, $urandom_range(0, 3));
                        default: set_req(i, $urandom, $urandom_range(0, 31), $urandom_range(0, 3));
                    endcase
                end
                req_valid[i] = pend[i];
            end
            resp_ready = ($urandom_range(0, 99) < 70);
            run_cycle(1'b0, dummy);
            last_rdy = m_rdy;
            for (int i = 0; i < NREQ; i++) if (last_rdy[i]) pend[i] = 0;
        end

`ifdef SHIFT_ARB_STATS_EN
        chk("cnt0_rand", 32'(grant_count[15:0]),  32'(m_cnt[0]));
        chk("cnt1_rand", 32'(grant_count[31:16]), 32'(m_cnt[1]));
`endif

        // Reach FULL via req0 (pointer moves to 1), then async reset mid-cycle.
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        run_cycle(1'b0, dummy);
        req_valid = 2'b01;
        set_req(0, 32'hDEAD_BEEF, 4, OP_SRL);
        resp_ready = 1'b0;
        run_cycle(1'b0, dummy);
        chk("pre_rst_full", 32'(resp_valid), 32'd1);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_ready", 32'(req_ready),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        resp_ready = 1'b1;
        run_cycle(1'b0, dummy);
        chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
        req_valid = 2'b11;
        set_req(0, 32'h0000_0003, 1, OP_SLL);
        set_req(1, 32'h0000_0030, 1, OP_SRL);
        run_cycle(1'b0, dummy);
        chk("first_grant_req0", 32'(resp_id), 32'd0);

`ifdef SHIFT_ARB_STATS_EN
        // After reset: one accept from req0 so far, add three from req1.
        req_valid = 2'b10;
        repeat (3) run_cycle(1'b0, dummy);
        req_valid = 2'b00;
        run_cycle(1'b0, dummy);
        chk("cnt0", 32'(grant_count[15:0]),  32'd1);
        chk("cnt1", 32'(grant_count[31:16]), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one shifter datapath (sll, srl, sra, selected by op) between NREQ requesters, e.g. the ALU issue stage and the load/store byte-align unit. Arbitration is round-robin with valid/ready handshakes. Results go into a one-entry output register tagged with the requester ID. One operation is in flight at a time, and back-to-back issue reaches full throughput.

Parameters:
N, 32, datapath width; shamt width is $clog2(N)
NREQ, 2, number of requesters (2..8); ID width IW = max(1, $clog2(NREQ))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
req_in  input  NREQ*N  packed operands; requester i at [i*N +: N]
req_shamt  input  NREQ*$clog2(N)  packed shift amounts
req_op  input  NREQ*2  packed shift_op_t
resp_valid  output  1  result register holds valid data
resp_ready  input  1  consumer accepts result
resp_out  output  N  shifted result
resp_id  output  IW  index of the requester that produced resp_out

Behaviour:
- Reset, asynchronous while rst_n=0:
  - resp_valid=0, resp_out=0, resp_id=0.
  - RR pointer=0, state=EMPTY.
  - req_ready=0 while in reset.
- States:
  - EMPTY: result register free.
  - FULL: result register holds an unconsumed result.
- can_accept = (state==EMPTY) || (resp_valid && resp_ready).
- Grant:
  - When can_accept, grant the first i with req_valid[i]=1, searching from the RR pointer upward with wrap.
  - req_ready[g]=1 for the granted index only. All other bits are 0.
  - If can_accept=0, all req_ready bits are 0.
- Accept is req_valid[g] && req_ready[g]. On the accepting edge:
  - resp_out <= shift(req_in[g], req_shamt[g], req_op[g]).
  - resp_id <= g, resp_valid <= 1, state <= FULL.
  - RR pointer <= (g+1) mod NREQ.
- Latency: exactly 1 cycle from accept to resp_valid.
- Simultaneous drain and accept in FULL: the register reloads with the new result and resp_valid stays 1. This gives one op per cycle of throughput.
- Drain without accept (resp_ready=1 and no request): resp_valid <= 0, state <= EMPTY. resp_out holds its last value.
- FULL with resp_ready=0: resp_out and resp_id are stable, and all req_ready bits are 0 (backpressure).
- With no requests, the RR pointer does not move.
- Ops:
  - SLL: in << shamt.
  - SRL: logical right shift, zero-fill.
  - SRA: sign-fill from in[N-1].
  - PASS: out = in, shamt ignored.
  - shamt=0 on any op gives out = in.
- Handshake rule: requesters must hold valid, in, shamt and op stable until they receive ready. The arbiter does not register request payloads.
- Reset mid-operation discards the pending result. No response is produced afterwards.

Optional Feature:
- Macro: SHIFT_ARB_STATS_EN.
- When defined:
  - Adds output port grant_count, NREQ*16 bits, packed per requester.
  - Each 16-bit field increments on every accept by that requester and wraps from 0xFFFF to 0.
  - All fields reset to 0.
- When undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- shifter_pkg holds:
  - shift_op_t, a 2-bit enum: SHIFT_SLL=0, SHIFT_SRL=1, SHIFT_SRA=2, SHIFT_PASS=3.
  - localparam SHIFT_N=32.
- One sub-module, rr_arbiter:
  - Parameter NREQ; inputs req and pointer; outputs one-hot grant and index.
  - Purely combinational; the pointer register stays in shift_arbiter.
- The shifter datapath instantiates the existing sll, srl and sra blocks plus a 4:1 result mux.

Test Plan:
- Reset then a single op: req0 SRA, in=0x8000_0000, shamt=4 → one cycle later resp_valid=1, resp_out=0xF800_0000, resp_id=0.
- Contention: req0 and req1 both valid continuously, resp_ready=1 → grants alternate 0,1,0,1. Each result appears 1 cycle after its grant, one per cycle.
- Backpressure: resp_ready=0 with result SLL 0x0000_0001 by 31 = 0x8000_0000 held → resp_out stable, req_ready=0 for 5 cycles. Raising resp_ready drains the result and accepts the next request in the same cycle.
- Op sweep: in=0xF000_000F, shamt=0 and 31 for SLL/SRL/SRA/PASS → 0x8000_0000 / 0x0000_0001 / 0xFFFF_FFFF / 0xF000_000F at 31. At shamt=0 all ops return the input unchanged.
- Reset asserted in FULL → resp_valid drops immediately (asynchronously) and no response follows after release. The first post-reset grant goes to req0 even if req1 was next.
- SHIFT_ARB_STATS_EN build: 3 accepts from req1 and 1 from req0 → grant_count fields read 1 (req0) and 3 (req1). Preloading a field to 0xFFFF and accepting once wraps it to 0.
